// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//
// Generates the 34-bit instruction word that drives the systolic core for two
// kinds of sequences:
//   * tile pass : load one kij weight tile into the PE array, stream the
//                 activations through it and drain the OFIFO into pmem at
//                 kij*stride.
//   * acc pass  : read the nine partial sums that contribute to one output
//                 pixel from pmem and accumulate them.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high
//   start_tile   request one kij tile pass (accepted only when idle)
//   start_acc    request one accumulation (start_tile has priority)
//   kij[3:0]     kernel index, latched with start_tile (0..8 legal)
//   onij[3:0]    output pixel index, latched with start_acc
//   ofifo_valid  core OFIFO holds data
//   inst[33:0]   registered instruction word
//   busy         sequence in progress
//   done         one-cycle completion pulse
//   err          one-cycle pulse for a rejected request
//
// Every output is registered from the current state, so each word appears one
// edge after the state that produces it.
// -----------------------------------------------------------------------------
module inst_sequencer #(
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int len_nij = 36,
   parameter int gap     = 10,
   parameter int stride  = 37
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_tile,
   input  logic        start_acc,
   input  logic [3:0]  kij,
   input  logic [3:0]  onij,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int EXEC_N = len_nij + row + col;
   localparam int CW     = $clog2(EXEC_N + col + gap + 16);

   localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

   // instruction bit positions
   localparam int B_ACC    = 33;
   localparam int B_CEN_P  = 32;
   localparam int B_WEN_P  = 31;
   localparam int B_CEN_X  = 19;
   localparam int B_OFF_RD = 6;
   localparam int B_L0_RD  = 3;
   localparam int B_L0_WR  = 2;
   localparam int B_EXEC   = 1;
   localparam int B_LOAD   = 0;

   localparam logic [CW-1:0] WL0_LAST  = CW'(col);
   localparam logic [CW-1:0] LDPE_ON   = CW'(col);
   localparam logic [CW-1:0] GAP_LAST  = CW'(gap - 1);
   localparam logic [CW-1:0] AL0_LAST  = CW'(len_nij);
   localparam logic [CW-1:0] EXEC_ON   = CW'(len_nij);
   localparam logic [CW-1:0] EXEC_LAST = CW'(EXEC_N - 1);
   localparam logic [CW-1:0] AREAD_LAST = CW'(9);

   localparam logic [10:0] STRIDE11 = 11'(stride);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WL0,
      S_LDPE,
      S_GAP,
      S_AL0,
      S_EXEC,
      S_DWAIT,
      S_DRAIN,
      S_DONE,
      S_AREAD
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] t_q, t_d;
   logic [3:0]    kij_q, kij_d;
   logic [3:0]    onij_q, onij_d;
   logic [33:0]   inst_q, inst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic [10:0]   jx;
   logic [10:0]   drain_base;
   logic [10:0]   acc_addr;

   // Partial sums are stored per kij at kij*stride; the acc pass walks the
   // 3x3 window of the 6x6 input that feeds output pixel onij (4x4 output).
   always_comb begin
      jx         = {7'd0, t_q[3:0]};
      drain_base = 11'(kij_q) * STRIDE11;
      acc_addr   = jx * STRIDE11
                 + ({9'd0, onij_q[3:2]} + jx / 11'd3) * 11'd6
                 + ({9'd0, onij_q[1:0]} + jx % 11'd3);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         kij_q   <= '0;
         onij_q  <= '0;
         inst_q  <= IDLE_WORD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         kij_q   <= kij_d;
         onij_q  <= onij_d;
         inst_q  <= inst_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      t_d     = t_q + CW'(1);
      kij_d   = kij_q;
      onij_d  = onij_q;
      inst_d  = IDLE_WORD;
      busy_d  = (state_q != S_IDLE);
      done_d  = (state_q == S_DONE);
      err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            t_d = '0;
            if (start_tile) begin
               if (kij > 4'd8) begin
                  err_d = 1'b1;
               end else begin
                  kij_d   = kij;
                  state_d = S_WL0;
               end
            end else if (start_acc) begin
               // every 4-bit onij addresses a valid 4x4 output pixel
               onij_d  = onij;
               state_d = S_AREAD;
            end
         end

         S_WL0: begin
            inst_d[B_CEN_X] = 1'b0;
            inst_d[17:7]    = 11'd1024 + 11'(t_q);
            // L0 captures the word read on the previous cycle
            inst_d[B_L0_WR] = (t_q != '0);
            if (t_q == WL0_LAST) begin
               state_d = S_LDPE;
               t_d     = '0;
            end
         end

         S_LDPE: begin
            inst_d[B_L0_RD] = (t_q < LDPE_ON);
            inst_d[B_LOAD]  = (t_q < LDPE_ON);
            if (t_q == WL0_LAST) begin
               state_d = S_GAP;
               t_d     = '0;
            end
         end

         S_GAP: begin
            if (t_q == GAP_LAST) begin
               state_d = S_AL0;
               t_d     = '0;
            end
         end

         S_AL0: begin
            inst_d[B_CEN_X] = 1'b0;
            inst_d[17:7]    = 11'(t_q);
            inst_d[B_L0_WR] = (t_q != '0);
            if (t_q == AL0_LAST) begin
               state_d = S_EXEC;
               t_d     = '0;
            end
         end

         S_EXEC: begin
            inst_d[B_EXEC]  = (t_q < EXEC_ON);
            inst_d[B_L0_RD] = (t_q < EXEC_ON);
            if (t_q == EXEC_LAST) begin
               // skip the wait entirely when the OFIFO is already ready
               state_d = ofifo_valid ? S_DRAIN : S_DWAIT;
               t_d     = '0;
            end
         end

         S_DWAIT: begin
            inst_d[B_OFF_RD] = 1'b1;
            t_d              = '0;
            if (ofifo_valid) begin
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            inst_d[B_OFF_RD] = 1'b1;
            inst_d[B_CEN_P]  = 1'b0;
            inst_d[B_WEN_P]  = 1'b0;
            inst_d[30:20]    = drain_base + 11'(t_q);
            if (t_q == AL0_LAST) begin
               state_d = S_DONE;
               t_d     = '0;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
            t_d     = '0;
         end

         S_AREAD: begin
            // j=9 is a pure accumulate cycle for the word read at j=8
            if (t_q != AREAD_LAST) begin
               inst_d[B_CEN_P] = 1'b0;
               inst_d[30:20]   = acc_addr;
            end
            inst_d[B_ACC] = (t_q != '0);
            if (t_q == AREAD_LAST) begin
               state_d = S_DONE;
               t_d     = '0;
            end
         end

         default: begin
            state_d = S_IDLE;
            t_d     = '0;
         end
      endcase
   end

   assign inst = inst_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

   localparam int COL    = 8;
   localparam int ROW    = 8;
   localparam int LEN    = 36;
   localparam int GAP    = 10;
   localparam int STRIDE = 37;

   localparam int EXEC_N     = LEN + ROW + COL;
   localparam int AL0_START  = 2 * (COL + 1) + GAP;
   localparam int EXEC_START = AL0_START + LEN + 1;
   localparam int PRE_DRAIN  = EXEC_START + EXEC_N;

   localparam logic [33:0] IDLE_W  = 34'h1_800C_0000;
   localparam logic [33:0] DWAIT_W = 34'h1_800C_0040;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_tile;
   logic        start_acc;
   logic [3:0]  kij;
   logic [3:0]  onij;
   logic        ofifo_valid;
   logic [33:0] inst;
   logic        busy;
   logic        done;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   logic [33:0] exp_q[$];

   int r_first, r_last, r_pre, r_busy, r_done, r_dwait;
   int acc_a [0:9];
   int r_acc, r_acc_first;

   inst_sequencer #(
      .col(COL), .row(ROW), .len_nij(LEN), .gap(GAP), .stride(STRIDE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start_tile(start_tile),
      .start_acc(start_acc),
      .kij(kij),
      .onij(onij),
      .ofifo_valid(ofifo_valid),
      .inst(inst),
      .busy(busy),
      .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Build one instruction word from named fields; everything not given
   // keeps its idle value.
   function automatic logic [33:0] mk(bit cenx, int ax, bit l0wr, bit l0rd,
                                      bit ld, bit exe, bit ofrd, bit cenp,
                                      bit wenp, int ap, bit acc);
      logic [33:0] w;
      w        = IDLE_W;
      w[19]    = cenx;
      w[17:7]  = 11'(ax);
      w[2]     = l0wr;
      w[3]     = l0rd;
      w[0]     = ld;
      w[1]     = exe;
      w[6]     = ofrd;
      w[32]    = cenp;
      w[31]    = wenp;
      w[30:20] = 11'(ap);
      w[33]    = acc;
      return w;
   endfunction

   // Expected word stream for a tile pass, phase by phase, ending with DONE.
   function automatic void build_tile(int k, int nd);
      exp_q.delete();
      for (int t = 0; t <= COL; t++) exp_q.push_back(mk(0, 1024 + t, t >= 1, 0, 0, 0, 0, 1, 1, 0, 0));
      for (int t = 0; t <= COL; t++) exp_q.push_back(mk(1, 0, 0, t < COL, t < COL, 0, 0, 1, 1, 0, 0));
      for (int t = 0; t < GAP; t++) exp_q.push_back(IDLE_W);
      for (int t = 0; t <= LEN; t++) exp_q.push_back(mk(0, t, t >= 1, 0, 0, 0, 0, 1, 1, 0, 0));
      for (int t = 0; t < EXEC_N; t++) exp_q.push_back(mk(1, 0, 0, t < LEN, 0, t < LEN, 0, 1, 1, 0, 0));
      for (int t = 0; t < nd; t++) exp_q.push_back(DWAIT_W);
      for (int t = 0; t <= LEN; t++) exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, k * STRIDE + t, 0));
      exp_q.push_back(IDLE_W);
   endfunction

   // Expected stream for an accumulation: the 3x3 input window feeding
   // output pixel o of a 4x4 output over a 6x6 input, one kij tile each.
   function automatic void build_acc(int o);
      int orow, ocol;
      orow = o / 4;
      ocol = o % 4;
      exp_q.delete();
      for (int j = 0; j < 9; j++)
         exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,
                            j * STRIDE + (orow + j / 3) * 6 + (ocol + j % 3), j >= 1));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
      exp_q.push_back(IDLE_W);
   endfunction

   task automatic run_tile(input int k, input int nd, input bit poke);
      int sz;
      build_tile(k, nd);
      sz = exp_q.size();
      r_first = -1; r_last = -1; r_pre = -1; r_busy = 0; r_done = 0; r_dwait = 0;
      @(negedge clk);
      ofifo_valid = (nd == 0);
      start_tile  = 1'b1;
      kij         = 4'(k);
      start_acc   = 1'($urandom_range(0, 1));
      onij        = 4'($urandom);
      @(posedge clk);
      @(negedge clk);
      start_tile = 1'b0;
      start_acc  = 1'b0;
      kij        = 4'($urandom);
      onij       = 4'($urandom);
      n_chk++;
      if (inst !== IDLE_W || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL tile_first_word_lag k=%0d: inst=%h busy=%b, expected inst=%h busy=0", k, inst, busy, IDLE_W);
      end
      for (int i = 0; i < sz; i++) begin
         @(negedge clk);
         n_chk++;
         if (inst !== exp_q[i] || busy !== 1'b1 || done !== (i == sz - 1) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tile_word k=%0d idx=%0d: inst=%h busy=%b done=%b err=%b, expected inst=%h busy=1 done=%b err=0",
                     k, i, inst, busy, done, err, exp_q[i], (i == sz - 1));
         end
         if (inst[32] == 1'b0 && inst[31] == 1'b0) begin
            if (r_first < 0) begin
               r_first = int'(inst[30:20]);
               r_pre   = i;
            end
            r_last = int'(inst[30:20]);
         end
         if (inst === DWAIT_W) r_dwait++;
         else if (busy === 1'b1) r_busy++;
         if (done === 1'b1) r_done++;
         if (poke && i == EXEC_START + 3) begin
            start_acc  = 1'b1;
            onij       = 4'($urandom);
            start_tile = 1'b1;
            kij        = 4'($urandom);
         end
         if (poke && i == EXEC_START + 10) begin
            start_acc  = 1'b0;
            start_tile = 1'b0;
         end
         if (nd >= 2 && i == PRE_DRAIN + nd - 2) ofifo_valid = 1'b1;
      end
      @(negedge clk);
      n_chk++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL tile_return_idle k=%0d: inst=%h busy=%b done=%b, expected inst=%h busy=0 done=0", k, inst, busy, done, IDLE_W);
      end
      ofifo_valid = 1'b1;
   endtask

   task automatic run_acc(input int o);
      int sz;
      build_acc(o);
      sz = exp_q.size();
      r_acc = 0; r_acc_first = -1;
      @(negedge clk);
      start_acc = 1'b1;
      onij      = 4'(o);
      @(posedge clk);
      @(negedge clk);
      start_acc = 1'b0;
      onij      = 4'($urandom);
      for (int i = 0; i < sz; i++) begin
         @(negedge clk);
         n_chk++;
         if (inst !== exp_q[i] || busy !== 1'b1 || done !== (i == sz - 1) || err !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_word onij=%0d idx=%0d: inst=%h busy=%b done=%b err=%b, expected inst=%h busy=1 done=%b err=0",
                     o, i, inst, busy, done, err, exp_q[i], (i == sz - 1));
         end
         if (i < 10) acc_a[i] = (inst[32] == 1'b0) ? int'(inst[30:20]) : -1;
         if (inst[33] === 1'b1) begin
            r_acc++;
            if (r_acc_first < 0) r_acc_first = i;
         end
      end
      @(negedge clk);
      n_chk++;
      if (inst !== IDLE_W || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL acc_return_idle onij=%0d: inst=%h busy=%b, expected inst=%h busy=0", o, inst, busy, IDLE_W);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_chk++;
      if (inst !== IDLE_W) begin
         n_fail++;
         $display("FAIL reset_inst: inst=%h, expected %h", inst, IDLE_W);
      end
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: busy=%b done=%b err=%b, expected all 0", busy, done, err);
      end
   endtask

   task automatic test_tile_basic();
      run_tile(0, 0, 0);
      n_chk++;
      if (r_pre !== PRE_DRAIN) begin
         n_fail++;
         $display("FAIL tile_pre_drain_cycles: got %0d, expected %0d", r_pre, PRE_DRAIN);
      end
      n_chk++;
      if (r_first !== 0 || r_last !== 36) begin
         n_fail++;
         $display("FAIL tile_drain_range_k0: got %0d..%0d, expected 0..36", r_first, r_last);
      end
      n_chk++;
      if (r_done !== 1) begin
         n_fail++;
         $display("FAIL tile_done_count: got %0d, expected 1", r_done);
      end
      n_chk++;
      if (r_busy !== PRE_DRAIN + LEN + 2) begin
         n_fail++;
         $display("FAIL tile_busy_cycles: got %0d, expected %0d", r_busy, PRE_DRAIN + LEN + 2);
      end
   endtask

   task automatic test_tile_random();
      for (int n = 0; n < 3; n++) begin
         int k;
         k = $urandom_range(1, 7);
         run_tile(k, 0, 0);
         n_chk++;
         if (r_first !== k * STRIDE || r_last !== k * STRIDE + LEN) begin
            n_fail++;
            $display("FAIL tile_drain_range k=%0d: got %0d..%0d, expected %0d..%0d", k, r_first, r_last, k * STRIDE, k * STRIDE + LEN);
         end
      end
   endtask

   task automatic test_dwait();
      run_tile(8, 20, 0);
      n_chk++;
      if (r_dwait !== 20) begin
         n_fail++;
         $display("FAIL dwait_cycles: got %0d, expected 20", r_dwait);
      end
      n_chk++;
      if (r_first !== 296 || r_last !== 332) begin
         n_fail++;
         $display("FAIL drain_range_k8: got %0d..%0d, expected 296..332", r_first, r_last);
      end
   endtask

   task automatic test_acc();
      int exp_a [9];
      exp_a = '{7, 45, 83, 124, 162, 200, 241, 279, 317};
      run_acc(5);
      for (int j = 0; j < 9; j++) begin
         n_chk++;
         if (acc_a[j] !== exp_a[j]) begin
            n_fail++;
            $display("FAIL acc_addr_onij5 j=%0d: got %0d, expected %0d", j, acc_a[j], exp_a[j]);
         end
      end
      n_chk++;
      if (r_acc !== 9 || r_acc_first !== 1) begin
         n_fail++;
         $display("FAIL acc_pulse_onij5: count=%0d first=%0d, expected count=9 first=1", r_acc, r_acc_first);
      end
      run_acc(0);
      run_acc(15);
      run_acc($urandom_range(1, 14));
   endtask

   task automatic test_illegal();
      int ks [3];
      ks = '{9, 15, 0};
      ks[2] = $urandom_range(10, 14);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         start_tile = 1'b1;
         start_acc  = 1'b1;
         kij        = 4'(ks[n]);
         @(posedge clk);
         @(negedge clk);
         start_tile = 1'b0;
         start_acc  = 1'b0;
         n_chk++;
         if (err !== 1'b1 || busy !== 1'b0 || inst !== IDLE_W) begin
            n_fail++;
            $display("FAIL illegal_kij_err kij=%0d: err=%b busy=%b inst=%h, expected err=1 busy=0 inst=%h", ks[n], err, busy, inst, IDLE_W);
         end
         @(negedge clk);
         n_chk++;
         if (err !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) begin
            n_fail++;
            $display("FAIL illegal_kij_after kij=%0d: err=%b busy=%b inst=%h, expected err=0 busy=0 inst=%h", ks[n], err, busy, inst, IDLE_W);
         end
      end
   endtask

   task automatic test_ignore_busy();
      run_tile(2, 0, 1);
      repeat (2) begin
         @(negedge clk);
         n_chk++;
         if (inst !== IDLE_W || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_launched: inst=%h busy=%b, expected inst=%h busy=0", inst, busy, IDLE_W);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [33:0] w;
      w = mk(1, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
      @(negedge clk);
      start_tile = 1'b1;
      kij        = 4'($urandom_range(0, 8));
      @(posedge clk);
      @(negedge clk);
      start_tile = 1'b0;
      for (int i = 0; i <= EXEC_START + 20; i++) @(negedge clk);
      n_chk++;
      if (inst !== w) begin
         n_fail++;
         $display("FAIL exec_cycle20_word: inst=%h, expected %h", inst, w);
      end
      reset = 1'b1;
      #1;
      n_chk++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_mid: inst=%h busy=%b done=%b err=%b, expected inst=%h busy=0 done=0 err=0", inst, busy, done, err, IDLE_W);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      run_tile(3, 0, 0);
      n_chk++;
      if (r_first !== 111 || r_last !== 147 || r_done !== 1) begin
         n_fail++;
         $display("FAIL post_reset_k3: drain %0d..%0d done=%0d, expected 111..147 done=1", r_first, r_last, r_done);
      end
   endtask

   initial begin
      reset       = 1'b1;
      start_tile  = 1'b0;
      start_acc   = 1'b0;
      kij         = 4'd0;
      onij        = 4'd0;
      ofifo_valid = 1'b1;
      repeat (2) @(posedge clk);
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      test_tile_basic();
      test_tile_random();
      test_dwait();
      test_acc();
      test_illegal();
      test_ignore_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
